// File: rtl/serial_result_writer.sv
// Write-back stage: buffers accumulator results and writes them to the shared 64x8 memory.
// Optional build macro SERIAL_RESULT_WRITER_SATURATE_EN stores 8'hFF for results above 8 bits.
module serial_result_writer #(
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       result_baseaddr,
  input  logic [7:0]       num_results,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             acc_valid,
  output logic             acc_ready,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             we,
  output logic [5:0]       addr,
  output logic [7:0]       d,
  output logic             is_done_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [7:0]       r_base;
  logic [7:0]       r_num;
  logic [7:0]       r_index;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_is_done;
  logic             r_overflow;

  logic       w_run;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_last;
  logic [7:0] w_push_data;
  logic [7:0] w_index_inc;
  logic [7:0] w_addr_sum;
  logic       w_unused;

  assign w_run       = (r_state == S_RUN);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign acc_ready   = w_run & ~w_full;
  assign mem_req     = w_run & ~w_empty;
  assign we          = mem_req & mem_gnt;
  assign w_push      = acc_valid & acc_ready;
  assign w_index_inc = r_index + 8'd1;
  assign w_last      = we & (w_index_inc == r_num);
  assign w_addr_sum  = r_base + r_index;
  assign addr        = w_addr_sum[5:0];
  assign d           = r_mem[r_rd_ptr];
  assign is_done_o   = r_is_done;
  assign overflow_o  = r_overflow;
  assign w_unused    = ^{w_addr_sum[7:6], acc_in[ACC_W-1:8]};

  // Value captured into the buffer at push time
  always_comb begin
    w_push_data = acc_in[7:0];
`ifdef SERIAL_RESULT_WRITER_SATURATE_EN
    if (acc_in[ACC_W-1:8] != '0) w_push_data = 8'hFF;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = (num_results == 8'd0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Run registers, result buffer and status flags; the buffer is flushed on the final write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_num      <= '0;
      r_index    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_is_done  <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      r_is_done <= (r_state == S_DONE);

      if ((r_state == S_IDLE) && en) begin
        r_base     <= result_baseaddr;
        r_num      <= num_results;
        r_index    <= '0;
        r_overflow <= 1'b0;
      end else if (we) begin
        r_index <= w_index_inc;
      end

      if (w_run && acc_valid && !acc_ready) r_overflow <= 1'b1;

      if (w_push) r_mem[r_wr_ptr] <= w_push_data;

      if (w_last) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (we)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, we})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_result_writer.sv
// Bench for serial_result_writer: directed scenarios plus random traffic against a queue-based model.
module tb_serial_result_writer;

  localparam int unsigned ACC_W = 16;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  base_i;
  logic [7:0]  num_i;
  logic [15:0] acc_in;
  logic        acc_valid;
  logic        acc_ready;
  logic        mem_req;
  logic        mem_gnt;
  logic        we;
  logic [5:0]  addr;
  logic [7:0]  d;
  logic        is_done_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 running, 2 finishing
  int         m_phase = 0;
  logic [7:0] m_q[$];
  int         m_idx   = 0;
  int         m_base  = 0;
  int         m_cnt   = 0;
  logic       m_ovf   = 1'b0;
  logic       m_done  = 1'b0;

  int log_addr[$];
  int log_d[$];

  serial_result_writer #(.ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en),
    .result_baseaddr(base_i), .num_results(num_i),
    .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .mem_req(mem_req), .mem_gnt(mem_gnt),
    .we(we), .addr(addr), .d(d),
    .is_done_o(is_done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] stored(input logic [15:0] v);
`ifdef SERIAL_RESULT_WRITER_SATURATE_EN
    return (v > 16'd255) ? 8'hFF : 8'(v % 16'd256);
`else
    return 8'(v % 16'd256);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit run;
    bit req;
    run = (m_phase == 1);
    req = run && (m_q.size() > 0);
    chk("acc_ready", 32'(acc_ready), 32'(run && (m_q.size() < int'(DEPTH))));
    chk("mem_req", 32'(mem_req), 32'(req));
    chk("we", 32'(we), 32'(req && mem_gnt));
    chk("addr", 32'(addr), 32'((m_base + m_idx) % 64));
    chk("is_done_o", 32'(is_done_o), 32'(m_done));
    chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
    if (req) chk("d", 32'(d), 32'(m_q[0]));
    if (we === 1'b1) begin
      log_addr.push_back(int'(addr));
      log_d.push_back(int'(d));
    end
  endtask

  task automatic model_update();
    bit rdy;
    bit wrote;
    logic nd;
    if (rst) begin
      m_phase = 0; m_q.delete(); m_idx = 0; m_base = 0; m_cnt = 0;
      m_ovf = 1'b0; m_done = 1'b0;
      return;
    end
    nd    = (m_phase == 2);
    rdy   = m_q.size() < int'(DEPTH);
    wrote = (m_phase == 1) && (m_q.size() > 0) && mem_gnt;
    case (m_phase)
      0: if (en) begin
        m_base = int'(base_i); m_cnt = int'(num_i); m_idx = 0; m_ovf = 1'b0;
        m_phase = (num_i == 8'd0) ? 2 : 1;
      end
      1: begin
        if (acc_valid && !rdy) m_ovf = 1'b1;
        if (wrote) begin void'(m_q.pop_front()); m_idx++; end
        if (acc_valid && rdy) m_q.push_back(stored(acc_in));
        if (wrote && (m_idx == m_cnt)) begin m_phase = 2; m_q.delete(); end
      end
      default: m_phase = 0;
    endcase
    m_done = nd;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic start(input logic [7:0] b, input logic [7:0] n);
    en = 1'b1; base_i = b; num_i = n; acc_valid = 1'b0;
    tick();
    en = 1'b0;
  endtask

  task automatic push(input logic [15:0] v, input logic g);
    acc_valid = 1'b1; acc_in = v; mem_gnt = g;
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic g);
    mem_gnt = g;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; base_i = '0; num_i = '0;
    acc_in = '0; acc_valid = 1'b0; mem_gnt = 1'b0;
    tick(); tick();
    chk("reset_d", 32'(d), 32'h0);
    rst = 1'b0;

    // Basic run
    log_addr.delete(); log_d.delete();
    start(8'h20, 8'd3);
    push(16'h0011, 1'b1); push(16'h0022, 1'b1); push(16'h0033, 1'b1);
    idle(4, 1'b1);
    chk("basic_nwrites", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      chk("basic_a0", 32'(log_addr[0]), 32'h20); chk("basic_d0", 32'(log_d[0]), 32'h11);
      chk("basic_a1", 32'(log_addr[1]), 32'h21); chk("basic_d1", 32'(log_d[1]), 32'h22);
      chk("basic_a2", 32'(log_addr[2]), 32'h22); chk("basic_d2", 32'(log_d[2]), 32'h33);
    end

    // Backpressure with grant withheld
    log_addr.delete(); log_d.delete();
    start(8'h00, 8'd4);
    for (int i = 0; i < 10; i++) push(16'($urandom), 1'b0);
    chk("bp_overflow", 32'(overflow_o), 32'h1);
    idle(4, 1'b1);
    chk("bp_nwrites", 32'(log_addr.size()), 32'd2);
    push(16'h0044, 1'b1); push(16'h0055, 1'b1);
    idle(4, 1'b1);
    chk("bp_total", 32'(log_addr.size()), 32'd4);

    // Address wrap
    log_addr.delete(); log_d.delete();
    start(8'h3F, 8'd2);
    push(16'h00A1, 1'b1); push(16'h00A2, 1'b1);
    idle(4, 1'b1);
    if (log_addr.size() == 2) begin
      chk("wrap_a0", 32'(log_addr[0]), 32'h3F);
      chk("wrap_a1", 32'(log_addr[1]), 32'h00);
    end else chk("wrap_nwrites", 32'(log_addr.size()), 32'd2);

    // Saturation / truncation
    log_addr.delete(); log_d.delete();
    start(8'h10, 8'd1);
    push(16'h0123, 1'b1);
    idle(3, 1'b1);
    if (log_d.size() == 1) begin
`ifdef SERIAL_RESULT_WRITER_SATURATE_EN
      chk("sat_d", 32'(log_d[0]), 32'hFF);
`else
      chk("sat_d", 32'(log_d[0]), 32'h23);
`endif
    end else chk("sat_nwrites", 32'(log_d.size()), 32'd1);

    // Zero count: results offered are ignored
    log_addr.delete(); log_d.delete();
    start(8'h07, 8'd0);
    push(16'h0099, 1'b1); push(16'h0098, 1'b1);
    idle(2, 1'b1);
    chk("zero_nwrites", 32'(log_addr.size()), 32'd0);

    // Reset mid-run, then restart at index 0
    start(8'h30, 8'd3);
    push(16'h0001, 1'b1); push(16'h0002, 1'b1);
    rst = 1'b1; acc_valid = 1'b1;
    tick();
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_ready", 32'(acc_ready), 32'h0);
    rst = 1'b0; acc_valid = 1'b0;
    log_addr.delete(); log_d.delete();
    start(8'h05, 8'd2);
    push(16'h0061, 1'b1); push(16'h0062, 1'b1);
    idle(4, 1'b1);
    if (log_addr.size() == 2) begin
      chk("restart_a0", 32'(log_addr[0]), 32'h05);
      chk("restart_d1", 32'(log_d[1]), 32'h62);
    end else chk("restart_nwrites", 32'(log_addr.size()), 32'd2);

    // Random traffic, stray starts and occasional resets
    for (int r = 0; r < 25; r++) begin
      start(8'($urandom), 8'($urandom_range(0, 5)));
      for (int c = 0; c < 30; c++) begin
        acc_valid = ($urandom % 3) != 0;
        acc_in    = 16'($urandom % ((r % 2 == 0) ? 256 : 65536));
        mem_gnt   = ($urandom % 4) != 0;
        en        = ($urandom % 16) == 0;
        base_i    = 8'($urandom);
        num_i     = 8'($urandom_range(0, 4));
        rst       = ($urandom % 80) == 0;
        tick();
      end
      en = 1'b0; rst = 1'b0; acc_valid = 1'b0;
      idle(3, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
